// File: rtl/cube_motion_scheduler.sv
// cube_motion_scheduler: queues decoded movement pulses into a small FIFO and issues
// them one at a time to the rotation executor. Scans run only when nothing is queued or
// in flight. Scanner-reset and user-reset requests are also handled here.
module cube_motion_scheduler #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic                       I_sys_clk,
    input  logic                       I_rst,
    input  logic [6:0]                 I_cmd_pulse,
    input  logic                       I_exec_done,
    input  logic                       I_scan_done,
    output logic                       O_exec_start,
    output logic [1:0]                 O_exec_cmd,
    output logic                       O_exec_abort,
    output logic                       O_scan_start,
    output logic                       O_scan_rst,
    output logic                       O_busy,
    output logic [$clog2(DEPTH):0]     O_queue_count,
    output logic                       O_overflow,
    output logic                       O_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC);
    // The abort/rst pulse is registered, so the wait ends one count early; the pulse
    // then lands in the cycle where the counter would have reached TIMEOUT_CYC-1.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 2);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_EXEC, WAIT_SCAN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            start_q, start_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            abort_q, abort_d;
    logic            scan_start_q, scan_start_d;
    logic            scan_rst_q, scan_rst_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic            tmo_q, tmo_d;

    logic            pop, push_ok, timed_out;
    logic [1:0]      push_cmd;

    // Next-state, FIFO bookkeeping and output pulses; user reset is applied last so it wins.
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pend_d       = pend_q;
        cmd_d        = cmd_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        start_d      = 1'b0;
        abort_d      = 1'b0;
        scan_start_d = 1'b0;
        scan_rst_d   = 1'b0;
        pop          = 1'b0;
        push_ok      = 1'b0;
        timed_out    = (cnt_q == TO_LAST);

        // lowest set movement bit wins
        if (I_cmd_pulse[0])      push_cmd = 2'd0;
        else if (I_cmd_pulse[1]) push_cmd = 2'd1;
        else if (I_cmd_pulse[2]) push_cmd = 2'd2;
        else                     push_cmd = 2'd3;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    start_d  = 1'b1;
                    cmd_d    = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = WAIT_EXEC;
                end else if (pend_q && !I_cmd_pulse[5]) begin
                    scan_start_d = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = WAIT_SCAN;
                end
            end
            WAIT_EXEC: begin
                if (I_exec_done) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    abort_d = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_SCAN: begin
                if (I_scan_done) begin
                    state_d = IDLE;
                end else if (timed_out) begin
                    scan_rst_d = 1'b1;
                    tmo_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // a slot freed by this cycle's pop can take the incoming move
        if (|I_cmd_pulse[3:0]) begin
            if (count_q == FULL && !pop) begin
                ovf_d = 1'b1;
            end else begin
                push_ok         = 1'b1;
                mem_d[wr_ptr_q] = push_cmd;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

        if (I_cmd_pulse[4] && !pend_q && state_q != WAIT_SCAN)
            pend_d = 1'b1;

        if (I_cmd_pulse[5]) begin
            scan_rst_d = 1'b1;
            pend_d     = 1'b0;
            if (state_q == WAIT_SCAN)
                state_d = IDLE;
        end

        if (I_cmd_pulse[6]) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pend_d       = 1'b0;
            ovf_d        = 1'b0;
            tmo_d        = 1'b0;
            cmd_d        = cmd_q;
            start_d      = 1'b0;
            scan_start_d = 1'b0;
            abort_d      = (state_q == WAIT_EXEC);
            scan_rst_d   = (state_q == WAIT_SCAN);
        end

        // wait counter restarts on every state change and idles at zero
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
        else                                        cnt_d = cnt_q + CW'(1);

        busy_d = (state_q != IDLE) || (count_q != '0);
    end

    // State, FIFO and registered outputs
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            start_q      <= 1'b0;
            cmd_q        <= '0;
            abort_q      <= 1'b0;
            scan_start_q <= 1'b0;
            scan_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            start_q      <= start_d;
            cmd_q        <= cmd_d;
            abort_q      <= abort_d;
            scan_start_q <= scan_start_d;
            scan_rst_q   <= scan_rst_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
        end
    end

    assign O_exec_start  = start_q;
    assign O_exec_cmd    = cmd_q;
    assign O_exec_abort  = abort_q;
    assign O_scan_start  = scan_start_q;
    assign O_scan_rst    = scan_rst_q;
    assign O_busy        = busy_q;
    assign O_queue_count = count_q;
    assign O_overflow    = ovf_q;
    assign O_timeout     = tmo_q;
endmodule

// File: tb/tb_cube_motion_scheduler.sv
// Bench for cube_motion_scheduler: expected move commands go into a scoreboard queue when
// the pulse is driven and are popped when O_exec_start appears.
module tb_cube_motion_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cmd_pulse = '0;
    logic       exec_done = 1'b0;
    logic       scan_done = 1'b0;
    logic       exec_start, exec_abort, scan_start, scan_rst, busy, overflow, timeout;
    logic [1:0] exec_cmd;
    logic [3:0] queue_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int sb[$];

    cube_motion_scheduler #(.DEPTH(8), .TIMEOUT_CYC(16)) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_cmd_pulse(cmd_pulse),
        .I_exec_done(exec_done), .I_scan_done(scan_done),
        .O_exec_start(exec_start), .O_exec_cmd(exec_cmd), .O_exec_abort(exec_abort),
        .O_scan_start(scan_start), .O_scan_rst(scan_rst), .O_busy(busy),
        .O_queue_count(queue_count), .O_overflow(overflow), .O_timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic [6:0] v);
        cmd_pulse = v; tick(); cmd_pulse = '0;
    endtask

    task automatic done_exec();
        exec_done = 1'b1; tick(); exec_done = 1'b0;
    endtask

    task automatic done_scan();
        scan_done = 1'b1; tick(); scan_done = 1'b0;
    endtask

    // Push the lowest-set movement bit's command, as the scheduler should
    task automatic push_move(input logic [6:0] v);
        if (v[0]) sb.push_back(0); else if (v[1]) sb.push_back(1);
        else if (v[2]) sb.push_back(2); else sb.push_back(3);
        pulse(v);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!exec_start && n < 40) begin tick(); n++; end
        if (!exec_start) n = -1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin tick(); n++; end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if ({exec_start, exec_abort, scan_start, scan_rst, busy, overflow, timeout} !== 7'd0
            || queue_count !== 4'd0 || exec_cmd !== 2'd0) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        rst = 1'b0;
        repeat (2) tick();
        tests++;
        if (busy !== 1'b0 || queue_count !== 4'd0) begin
            fails++; $display("FAIL post_reset: busy=%0b count=%0d required 0/0", busy, queue_count);
        end
    endtask

    task automatic test_single();
        int n0, exp;
        n0 = cyc;
        push_move(7'b0000010);
        tests++;
        if (exec_start !== 1'b0) begin fails++; $display("FAIL single_early: start=1 at N+1, required 0"); end
        tick();
        tests++;
        exp = sb.pop_front();
        if (exec_start !== 1'b1 || cyc - n0 !== 2 || exec_cmd !== 2'(exp)) begin
            fails++; $display("FAIL single_latency: start=%0b lat=%0d cmd=%0d required 1/2/%0d",
                              exec_start, cyc - n0, exec_cmd, exp);
        end
        tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: busy=%0b required 1", busy); end
        done_exec();
        tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%0b required 0", busy); end
    endtask

    task automatic test_priority();
        int n, exp;
        push_move(7'b0001010);
        wait_start(n);
        exp = sb.pop_front();
        tests++;
        if (n < 0 || exec_cmd !== 2'(exp)) begin
            fails++; $display("FAIL lowest_wins: wait=%0d cmd=%0d required cmd %0d", n, exec_cmd, exp);
        end
        done_exec();
        wait_idle();
    endtask

    task automatic test_fifo_order();
        int n, exp;
        push_move(7'b0000010);
        wait_start(n);
        exp = sb.pop_front();
        tests++;
        if (n < 0 || exec_cmd !== 2'(exp)) begin
            fails++; $display("FAIL order_first: wait=%0d cmd=%0d required %0d", n, exec_cmd, exp);
        end
        push_move(7'b0000001);
        push_move(7'b0001000);
        push_move(7'b0000010);
        tests++;
        if (queue_count !== 4'd3) begin fails++; $display("FAIL order_count3: count=%0d required 3", queue_count); end
        for (int k = 0; k < 3; k++) begin
            done_exec();
            tests++;
            if (exec_start !== 1'b0) begin fails++; $display("FAIL order_early%0d: start=1 at M+1", k); end
            tick();
            exp = sb.pop_front();
            tests++;
            if (exec_start !== 1'b1 || exec_cmd !== 2'(exp) || queue_count !== 4'(2 - k)) begin
                fails++; $display("FAIL order_step%0d: start=%0b cmd=%0d count=%0d required 1/%0d/%0d",
                                  k, exec_start, exec_cmd, queue_count, exp, 2 - k);
            end
        end
        done_exec();
        wait_idle();
    endtask

    task automatic test_scan_after_moves();
        int n, exp;
        push_move(7'b0000100);
        wait_start(n);
        exp = sb.pop_front();
        tests++;
        if (n < 0 || exec_cmd !== 2'(exp)) begin fails++; $display("FAIL scan_mv0: cmd=%0d required %0d", exec_cmd, exp); end
        pulse(7'b0010000);
        push_move(7'b0000001);
        done_exec();
        tick();
        exp = sb.pop_front();
        tests++;
        if (exec_start !== 1'b1 || exec_cmd !== 2'(exp) || scan_start !== 1'b0) begin
            fails++; $display("FAIL scan_move_first: start=%0b cmd=%0d scan=%0b required 1/%0d/0",
                              exec_start, exec_cmd, scan_start, exp);
        end
        done_exec();
        tick();
        tests++;
        if (scan_start !== 1'b1 || exec_start !== 1'b0) begin
            fails++; $display("FAIL scan_start: scan=%0b start=%0b required 1/0", scan_start, exec_start);
        end
        tick();
        done_scan();
        wait_idle();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL scan_idle: busy=%0b required 0", busy); end
    endtask

    task automatic test_overflow();
        int n, exp;
        logic [6:0] pat [4];
        pat[0] = 7'b0000001; pat[1] = 7'b0000010; pat[2] = 7'b0000100; pat[3] = 7'b0001000;
        push_move(7'b0001000);
        wait_start(n);
        exp = sb.pop_front();
        tests++;
        if (n < 0 || exec_cmd !== 2'(exp)) begin fails++; $display("FAIL ovf_mv0: cmd=%0d required %0d", exec_cmd, exp); end
        for (int k = 0; k < 8; k++) push_move(pat[(k * 3 + 1) % 4]);
        pulse(7'b0000001);
        tests++;
        if (queue_count !== 4'd8 || overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_full: count=%0d ovf=%0b required 8/1", queue_count, overflow);
        end
        for (int k = 0; k < 8; k++) begin
            done_exec();
            wait_start(n);
            exp = sb.pop_front();
            tests++;
            if (n < 0 || exec_cmd !== 2'(exp)) begin
                fails++; $display("FAIL ovf_drain%0d: wait=%0d cmd=%0d required %0d", k, n, exec_cmd, exp);
            end
        end
        done_exec();
        n = 0;
        repeat (5) begin tick(); if (exec_start) n++; end
        tests++;
        if (n !== 0 || queue_count !== 4'd0) begin
            fails++; $display("FAIL ovf_ninth: extra starts=%0d count=%0d required 0/0", n, queue_count);
        end
        pulse(7'b1000000);
        tick();
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: ovf=%0b required 0", overflow); end
    endtask

    task automatic test_timeout();
        int n, s, exp;
        push_move(7'b0000010);
        wait_start(n);
        s = cyc;
        exp = sb.pop_front();
        tests++;
        if (n < 0 || exec_cmd !== 2'(exp)) begin fails++; $display("FAIL tmo_mv0: cmd=%0d required %0d", exec_cmd, exp); end
        push_move(7'b0000001);
        n = 0;
        while (!exec_abort && n < 30) begin tick(); n++; end
        tests++;
        if (!exec_abort || cyc - s !== 15 || timeout !== 1'b1) begin
            fails++; $display("FAIL tmo_abort: abort=%0b at offset %0d tmo=%0b required 1/15/1",
                              exec_abort, cyc - s, timeout);
        end
        tick();
        exp = sb.pop_front();
        tests++;
        if (exec_start !== 1'b1 || exec_cmd !== 2'(exp) || exec_abort !== 1'b0) begin
            fails++; $display("FAIL tmo_next: start=%0b cmd=%0d abort=%0b required 1/%0d/0",
                              exec_start, exec_cmd, exec_abort, exp);
        end
        done_exec();
        wait_idle();
        pulse(7'b1000000);
        tick();
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL tmo_clear: tmo=%0b required 0", timeout); end
    endtask

    task automatic test_scan_rst();
        int n, exp;
        pulse(7'b0100000);
        tests++;
        if (scan_rst !== 1'b1) begin fails++; $display("FAIL srst_pulse: rst=%0b required 1", scan_rst); end
        tick();
        tests++;
        if (scan_rst !== 1'b0) begin fails++; $display("FAIL srst_width: rst=%0b required 0", scan_rst); end
        push_move(7'b0000100);
        wait_start(n);
        exp = sb.pop_front();
        tests++;
        if (n < 0 || exec_cmd !== 2'(exp)) begin fails++; $display("FAIL srst_mv: cmd=%0d required %0d", exec_cmd, exp); end
        pulse(7'b0010000);
        pulse(7'b0100000);
        done_exec();
        n = 0;
        repeat (6) begin tick(); if (scan_start) n++; end
        tests++;
        if (n !== 0) begin fails++; $display("FAIL srst_clears_pending: scan starts=%0d required 0", n); end
    endtask

    task automatic test_user_rst_in_scan();
        int n;
        pulse(7'b0010000);
        tick();
        tests++;
        if (scan_start !== 1'b1) begin fails++; $display("FAIL urst_scan_go: scan=%0b required 1", scan_start); end
        push_move(7'b0000001);
        push_move(7'b0000010);
        tests++;
        if (queue_count !== 4'd2) begin fails++; $display("FAIL urst_queued: count=%0d required 2", queue_count); end
        pulse(7'b1000100);
        sb.delete();
        tests++;
        if (scan_rst !== 1'b1 || queue_count !== 4'd0 || overflow !== 1'b0 || timeout !== 1'b0) begin
            fails++; $display("FAIL urst_apply: srst=%0b count=%0d ovf=%0b tmo=%0b required 1/0/0/0",
                              scan_rst, queue_count, overflow, timeout);
        end
        n = 0;
        repeat (5) begin tick(); if (exec_start || scan_start) n++; end
        tests++;
        if (n !== 0 || busy !== 1'b0) begin
            fails++; $display("FAIL urst_idle: starts=%0d busy=%0b required 0/0", n, busy);
        end
    endtask

    task automatic test_async_reset();
        int n;
        push_move(7'b0001000);
        wait_start(n);
        void'(sb.pop_front());
        pulse(7'b0000001);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (queue_count !== 4'd0 || busy !== 1'b0 || exec_abort !== 1'b0 || exec_start !== 1'b0) begin
            fails++; $display("FAIL arst_now: count=%0d busy=%0b abort=%0b required 0/0/0",
                              queue_count, busy, exec_abort);
        end
        tick();
        rst = 1'b0;
        n = 0;
        repeat (4) begin tick(); if (exec_abort || exec_start) n++; end
        sb.delete();
        tests++;
        if (n !== 0) begin fails++; $display("FAIL arst_quiet: pulses after reset=%0d required 0", n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_fifo_order();
        test_scan_after_moves();
        test_overflow();
        test_timeout();
        test_scan_rst();
        test_user_rst_in_scan();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
